// File: rtl/trace_recorder.sv
// trace_recorder: per-cycle PC/writeback trace capture into a FIFO drained over valid/ready (optional TRACE_WB_ONLY_EN).
module trace_recorder #(
  parameter int XLEN       = 32,
  parameter int DEPTH      = 16,
  parameter int MAX_CYCLES = 30,
  parameter int CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [XLEN-1:0]  pc_i,
  input  logic             wb_en_i,
  input  logic [4:0]       wb_addr_i,
  input  logic [XLEN-1:0]  wb_data_i,
  input  logic             out_ready_i,
  output logic             out_valid_o,
  output logic [CNT_W-1:0] out_cycle_o,
  output logic [XLEN-1:0]  out_pc_o,
  output logic             out_wb_o,
  output logic [4:0]       out_rd_o,
  output logic [XLEN-1:0]  out_data_o,
  output logic             done_o,
  output logic             overflow_o,
  output logic [CNT_W-1:0] dropped_o
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(MAX_CYCLES - 1);
  typedef struct packed {
    logic [CNT_W-1:0] cycle;
    logic [XLEN-1:0]  pc;
    logic             wb;
    logic [4:0]       rd;
    logic [XLEN-1:0]  data;
  } entry_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state;
  logic [CNT_W-1:0] cyc;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  entry_t mem [DEPTH];
  entry_t head, wentry;
  logic wb, cap, push_req, full, pop, push, drop;
  assign wb = wb_en_i && (wb_addr_i != 5'd0);
  assign cap = start_i && (state != DONE);
`ifdef TRACE_WB_ONLY_EN
  assign push_req = cap && wb;
`else
  assign push_req = cap;
`endif
  assign full = count == FULL;
  assign pop = out_valid_o && out_ready_i;
  assign push = push_req && (!full || pop);
  assign drop = push_req && full && !pop;
  assign wentry = '{cycle: cyc, pc: pc_i, wb: wb, rd: wb ? wb_addr_i : 5'd0, data: wb ? wb_data_i : '0};
  assign head = mem[rd_ptr];
  assign out_valid_o = count != '0;
  assign out_cycle_o = out_valid_o ? head.cycle : '0;
  assign out_pc_o = out_valid_o ? head.pc : '0;
  assign out_wb_o = out_valid_o && head.wb;
  assign out_rd_o = out_valid_o ? head.rd : 5'd0;
  assign out_data_o = out_valid_o ? head.data : '0;
  assign done_o = state == DONE;
  // capture sequencing: the capture of the last stamp retires the recorder
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
      cyc <= '0;
    end else if (cap) begin
      cyc <= cyc + 1'b1;
      state <= (cyc == LAST) ? DONE : RUN;
    end
  end
  // fifo bookkeeping and drop accounting
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      overflow_o <= 1'b0;
      dropped_o <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) overflow_o <= 1'b1;
      if (drop && dropped_o != '1) dropped_o <= dropped_o + 1'b1;
    end
  end
  // entry storage needs no reset; occupancy gates visibility
  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= wentry;
  end
endmodule

// File: tb/tb_trace_recorder.sv
// tb_trace_recorder: randomized and directed checks of trace_recorder against a queue-based model.
module tb_trace_recorder;
  localparam int DEPTH = 16;
  localparam int MAXC = 30;
  logic clk_i = 1'b0;
  logic rst_i, start_i, wb_en_i, out_ready_i;
  logic [31:0] pc_i, wb_data_i;
  logic [4:0] wb_addr_i;
  logic out_valid_o, out_wb_o, done_o, overflow_o;
  logic [15:0] out_cycle_o, dropped_o;
  logic [31:0] out_pc_o, out_data_o;
  logic [4:0] out_rd_o;
  int n_vec = 0;
  int n_err = 0;
  typedef struct {
    int unsigned cyc;
    logic [31:0] pc;
    bit          wb;
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;
  ent_t q[$];
  int unsigned m_cyc, m_drop;
  bit m_done, m_ovf;

  trace_recorder #(.XLEN(32), .DEPTH(DEPTH), .MAX_CYCLES(MAXC), .CNT_W(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .pc_i(pc_i), .wb_en_i(wb_en_i),
    .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i), .out_ready_i(out_ready_i),
    .out_valid_o(out_valid_o), .out_cycle_o(out_cycle_o), .out_pc_o(out_pc_o),
    .out_wb_o(out_wb_o), .out_rd_o(out_rd_o), .out_data_o(out_data_o),
    .done_o(done_o), .overflow_o(overflow_o), .dropped_o(dropped_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_cyc = 0;
    m_drop = 0;
    m_done = 0;
    m_ovf = 0;
  endtask

  task automatic compare();
    check("valid", {63'd0, out_valid_o}, {63'd0, q.size() != 0});
    if (q.size() != 0) begin
      check("cycle", {48'd0, out_cycle_o}, 64'(q[0].cyc));
      check("pc", {32'd0, out_pc_o}, {32'd0, q[0].pc});
      check("wb", {63'd0, out_wb_o}, {63'd0, q[0].wb});
      check("rd", {59'd0, out_rd_o}, {59'd0, q[0].rd});
      check("data", {32'd0, out_data_o}, {32'd0, q[0].data});
    end
    check("done", {63'd0, done_o}, {63'd0, m_done});
    check("overflow", {63'd0, overflow_o}, {63'd0, m_ovf});
    check("dropped", {48'd0, dropped_o}, 64'(m_drop));
  endtask

  // called at a negedge; reset is asynchronous so outputs must clear before any edge
  task automatic do_reset();
    rst_i = 1'b1;
    #1;
    model_clear();
    compare();
    check("rst_cycle", {48'd0, out_cycle_o}, 64'd0);
    check("rst_pc", {32'd0, out_pc_o}, 64'd0);
    #1 rst_i = 1'b0;
  endtask

  task automatic step(input bit s, input logic [31:0] pc, input bit we, input logic [4:0] a,
                      input logic [31:0] d, input bit rdy);
    bit pop, wb, cap, req, full;
    start_i = s; pc_i = pc; wb_en_i = we; wb_addr_i = a; wb_data_i = d; out_ready_i = rdy;
    @(posedge clk_i);
    full = q.size() == DEPTH;
    pop = q.size() != 0 && rdy;
    wb = we && a != 0;
    cap = s && !m_done;
`ifdef TRACE_WB_ONLY_EN
    req = cap && wb;
`else
    req = cap;
`endif
    if (pop) void'(q.pop_front());
    if (req) begin
      if (full && !pop) begin
        m_ovf = 1;
        if (m_drop < 65535) m_drop++;
      end else q.push_back('{m_cyc, pc, wb, wb ? a : 5'd0, wb ? d : 32'd0});
    end
    if (cap) begin
      if (m_cyc == MAXC - 1) m_done = 1;
      m_cyc++;
    end
    @(negedge clk_i);
    compare();
  endtask

  task automatic drain();
    repeat (DEPTH + 4) step(0, $urandom, 0, 5'($urandom), $urandom, 1);
  endtask

  initial begin
    rst_i = 1'b1; start_i = 0; pc_i = 0; wb_en_i = 0; wb_addr_i = 0; wb_data_i = 0; out_ready_i = 0;
    model_clear();
    @(negedge clk_i);
    do_reset();
    for (int i = 0; i < MAXC + 5; i++)
      step(1, 32'(i * 4), i == 3 || i == 4, i == 3 ? 5'd5 : i == 4 ? 5'd0 : 5'($urandom),
           i == 3 ? 32'd7 : i == 4 ? 32'd9 : $urandom, 1);
    check("done_run1", {63'd0, done_o}, 64'd1);
    @(negedge clk_i);
    do_reset();
    for (int i = 0; i < MAXC + 2; i++) step(1, 32'(i * 4), $urandom_range(0, 1), 5'($urandom), $urandom, 0);
`ifndef TRACE_WB_ONLY_EN
    check("dropped_stall", {48'd0, dropped_o}, 64'd14);
`endif
    drain();
    do_reset();
    for (int i = 0; i < 20; i++) step(1, 32'(i * 4), 1, 5'($urandom), $urandom, 0);
    for (int i = 20; i < MAXC + 2; i++) step(1, 32'(i * 4), 1, 5'($urandom), $urandom, i % 3 == 0);
    drain();
    do_reset();
    for (int i = 0; i < 10; i++) step(i < 5 || i > 7, 32'(i * 4), 1, 5'(i + 1), $urandom, 0);
    do_reset();
    check("idle_after_rst", {63'd0, done_o}, 64'd0);
    for (int i = 0; i < 3; i++) step(0, $urandom, 1, 5'd1, $urandom, 1);
    for (int i = 0; i < MAXC + 2; i++) step(1, 32'(i * 4), i == 2 || i == 9, 5'd3, 32'(i), 1);
    for (int r = 0; r < 6; r++) begin
      do_reset();
      for (int i = 0; i < 70; i++)
        step($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 1), 5'($urandom), $urandom,
             $urandom_range(0, r % 3) == 0);
      drain();
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
